// File: rtl/alu_pipe_if.sv
// Handshake/operand bundle between the operand latch, the ALU stage and the
// execute stage. The ALU is the slave; its producer/consumer side is master.
interface alu_pipe_if #(
  parameter int WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             set_cc;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic [2:0]       cc;

  modport slave (
    input  in_valid, op, in_a, in_b, set_cc, out_ready,
    output in_ready, out_valid, out, cc
  );

  modport master (
    output in_valid, op, in_a, in_b, set_cc, out_ready,
    input  in_ready, out_valid, out, cc
  );
endinterface

// File: rtl/alu_pipe.sv
// Registered Y86-style ALU stage: ADD/SUB/AND/XOR with one cycle of latency,
// valid/ready on both sides, and a {ZF,SF,OF} condition-code register that is
// only written when an accepted transaction asks for it.
module alu_pipe #(
  parameter int         WIDTH    = 64,
  parameter logic [2:0] CC_RESET = 3'b100
) (
  input  logic        clk,
  input  logic        rst,
  alu_pipe_if.slave   bus
);
  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_AND = 2'd2;

  logic [WIDTH-1:0] out_q, out_d;
  logic             out_valid_q;
  logic [2:0]       cc_q, cc_d;
  logic             accept;
  logic             a_s, b_s, r_s, of_d;

  // A slot opens whenever the result register is empty or being drained.
  assign bus.in_ready = !out_valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;

  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.cc        = cc_q;

  assign a_s = bus.in_a[WIDTH-1];
  assign b_s = bus.in_b[WIDTH-1];
  assign r_s = out_d[WIDTH-1];

  // Result and flags; B is the left operand (B op A) as in Y86 OPq.
  always_comb begin
    out_d = '0;
    of_d  = 1'b0;
    case (bus.op)
      OP_ADD: begin
        out_d = bus.in_b + bus.in_a;
        of_d  = (a_s == b_s) && (r_s != a_s);
      end
      OP_SUB: begin
        out_d = bus.in_b - bus.in_a;
        of_d  = (a_s != b_s) && (r_s != b_s);
      end
      OP_AND:  out_d = bus.in_b & bus.in_a;
      default: out_d = bus.in_b ^ bus.in_a;
    endcase
    cc_d = {(out_d == '0), r_s, of_d};
  end

  // Result register, valid flag and condition codes; reset wins over all.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
      cc_q        <= CC_RESET;
    end else begin
      if (accept) begin
        out_q       <= out_d;
        out_valid_q <= 1'b1;
        if (bus.set_cc) cc_q <= cc_d;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: directed scenarios plus randomized traffic checked
// against a transaction-level model, and an 8-bit instance for width checks.
module tb_alu_pipe;
  logic clk;
  logic rst;
  int   checks;
  int   errs;

  alu_pipe_if #(.WIDTH(64)) bus ();
  alu_pipe_if #(.WIDTH(8))  bus8 ();

  alu_pipe #(.WIDTH(64), .CC_RESET(3'b100)) dut (.clk(clk), .rst(rst), .bus(bus));
  alu_pipe #(.WIDTH(8),  .CC_RESET(3'b100)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model state: what the result register / cc should hold.
  logic        m_valid;
  logic [63:0] m_out;
  logic [2:0]  m_cc;

  // Reference ALU: overflow via signed arithmetic one bit wider than the operands.
  function automatic void ref_alu(input logic [1:0] o, input logic [63:0] a, input logic [63:0] b,
                                  output logic [63:0] r, output logic [2:0] f);
    logic signed [64:0] w;
    logic ovf;
    ovf = 1'b0;
    w   = '0;
    case (o)
      2'd0: begin w = $signed({b[63], b}) + $signed({a[63], a}); r = w[63:0]; ovf = (w[64] != w[63]); end
      2'd1: begin w = $signed({b[63], b}) - $signed({a[63], a}); r = w[63:0]; ovf = (w[64] != w[63]); end
      2'd2: r = b & a;
      default: r = b ^ a;
    endcase
    f = {(r == 64'd0), r[63], ovf};
  endfunction

  // 8-bit reference using plain integer ranges.
  function automatic void ref8(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b,
                               output logic [7:0] r, output logic [2:0] f);
    int sa, sb, s;
    logic ovf;
    sa = int'($signed(a));
    sb = int'($signed(b));
    s = 0;
    ovf = 1'b0;
    case (o)
      2'd0: begin s = sb + sa; ovf = (s > 127) || (s < -128); r = 8'(s); end
      2'd1: begin s = sb - sa; ovf = (s > 127) || (s < -128); r = 8'(s); end
      2'd2: r = b & a;
      default: r = b ^ a;
    endcase
    f = {(r == 8'd0), r[7], ovf};
  endfunction

  // Advance one clock on the 64-bit DUT, updating the model from the
  // inputs that are presented at that edge.
  task automatic tick();
    logic        acc;
    logic [63:0] r;
    logic [2:0]  f;
    acc = bus.in_valid && (!m_valid || bus.out_ready);
    ref_alu(bus.op, bus.in_a, bus.in_b, r, f);
    @(posedge clk);
    if (rst) begin
      m_valid = 1'b0; m_out = '0; m_cc = 3'b100;
    end else if (acc) begin
      m_valid = 1'b1; m_out = r;
      if (bus.set_cc) m_cc = f;
    end else if (bus.out_ready) begin
      m_valid = 1'b0;
    end
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] o, input logic [63:0] a,
                       input logic [63:0] b, input logic sc, input logic ordy);
    bus.in_valid = v; bus.op = o; bus.in_a = a; bus.in_b = b;
    bus.set_cc = sc; bus.out_ready = ordy;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 2'd0, '0, '0, 1'b0, 1'b0);
    tick(); tick();
    rst = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errs++; $display("FAIL reset_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.out !== 64'd0) begin errs++; $display("FAIL reset_out got=%h exp=0", bus.out); end
    checks++; if (bus.cc !== 3'b100) begin errs++; $display("FAIL reset_cc got=%b exp=100", bus.cc); end
    checks++; if (bus.in_ready !== 1'b1) begin errs++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
  endtask

  task automatic test_and_xor();
    drive(1'b1, 2'd2, 64'h26, 64'h31, 1'b1, 1'b1);
    tick();
    checks++; if ({bus.out_valid, bus.out, bus.cc} !== {1'b1, 64'h20, 3'b000}) begin
      errs++; $display("FAIL and got v=%b out=%h cc=%b exp v=1 out=20 cc=000", bus.out_valid, bus.out, bus.cc); end
    drive(1'b1, 2'd3, 64'h26, 64'h31, 1'b1, 1'b1);
    tick();
    checks++; if ({bus.out_valid, bus.out, bus.cc} !== {1'b1, 64'h17, 3'b000}) begin
      errs++; $display("FAIL xor got v=%b out=%h cc=%b exp v=1 out=17 cc=000", bus.out_valid, bus.out, bus.cc); end
  endtask

  task automatic test_sub_add_of();
    drive(1'b1, 2'd1, 64'd5, 64'd5, 1'b1, 1'b1);
    tick();
    checks++; if ({bus.out, bus.cc} !== {64'd0, 3'b100}) begin
      errs++; $display("FAIL sub_zero got out=%h cc=%b exp out=0 cc=100", bus.out, bus.cc); end
    drive(1'b1, 2'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b1, 1'b1);
    tick();
    checks++; if ({bus.out, bus.cc} !== {64'h8000_0000_0000_0000, 3'b011}) begin
      errs++; $display("FAIL add_of got out=%h cc=%b exp out=8000000000000000 cc=011", bus.out, bus.cc); end
  endtask

  task automatic test_cc_hold();
    drive(1'b1, 2'd1, 64'd3, 64'd1, 1'b0, 1'b1);
    tick();
    checks++; if ({bus.out, bus.cc} !== {64'hFFFF_FFFF_FFFF_FFFE, 3'b011}) begin
      errs++; $display("FAIL cc_hold got out=%h cc=%b exp out=fffffffffffffffe cc=011", bus.out, bus.cc); end
    // set_cc offered without in_valid must not touch cc either
    drive(1'b0, 2'd1, 64'd5, 64'd5, 1'b1, 1'b1);
    tick();
    checks++; if ({bus.out_valid, bus.out, bus.cc} !== {1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 3'b011}) begin
      errs++; $display("FAIL cc_idle got v=%b out=%h cc=%b exp v=0 out=fffffffffffffffe cc=011", bus.out_valid, bus.out, bus.cc); end
  endtask

  task automatic test_backpressure();
    drive(1'b1, 2'd0, 64'd2, 64'd3, 1'b1, 1'b0);
    tick();
    drive(1'b1, 2'd0, 64'd10, 64'd20, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (bus.in_ready !== 1'b0) begin errs++; $display("FAIL bp_ready[%0d] got=%b exp=0", i, bus.in_ready); end
      tick();
      checks++; if ({bus.out_valid, bus.out, bus.cc} !== {1'b1, 64'd5, 3'b000}) begin
        errs++; $display("FAIL bp_hold[%0d] got v=%b out=%h cc=%b exp v=1 out=5 cc=000", i, bus.out_valid, bus.out, bus.cc); end
    end
    bus.out_ready = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errs++; $display("FAIL bp_release_ready got=%b exp=1", bus.in_ready); end
    tick();
    checks++; if ({bus.out_valid, bus.out} !== {1'b1, 64'd30}) begin
      errs++; $display("FAIL bp_swap got v=%b out=%h exp v=1 out=1e", bus.out_valid, bus.out); end
    bus.in_valid = 1'b0;
    tick();
    checks++; if ({bus.out_valid, bus.out} !== {1'b0, 64'd30}) begin
      errs++; $display("FAIL bp_drain got v=%b out=%h exp v=0 out=1e", bus.out_valid, bus.out); end
  endtask

  task automatic test_reset_mid_stall();
    drive(1'b1, 2'd1, 64'd1, 64'd9, 1'b1, 1'b0);
    tick();
    bus.in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checks++; if ({bus.out_valid, bus.out, bus.cc, bus.in_ready} !== {1'b0, 64'd0, 3'b100, 1'b1}) begin
      errs++; $display("FAIL rst_stall got v=%b out=%h cc=%b rdy=%b exp v=0 out=0 cc=100 rdy=1",
                       bus.out_valid, bus.out, bus.cc, bus.in_ready); end
  endtask

  task automatic test_random();
    logic [63:0] a, b;
    for (int i = 0; i < 400; i++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) a = {a[63], 63'h7FFF_FFFF_FFFF_FFF0 | a[3:0]};
      if ($urandom_range(0, 5) == 0) b = a;
      drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), a, b,
            $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0);
      #1;
      checks++; if (bus.in_ready !== (!m_valid || bus.out_ready)) begin
        errs++; $display("FAIL rnd_ready[%0d] got=%b exp=%b", i, bus.in_ready, !m_valid || bus.out_ready); end
      tick();
      checks++; if ({bus.out_valid, bus.out, bus.cc} !== {m_valid, m_out, m_cc}) begin
        errs++; $display("FAIL rnd[%0d] got v=%b out=%h cc=%b exp v=%b out=%h cc=%b",
                         i, bus.out_valid, bus.out, bus.cc, m_valid, m_out, m_cc); end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_width8();
    logic [7:0] a, b, r;
    logic [2:0] f;
    bus8.in_valid = 1'b1; bus8.op = 2'd0; bus8.in_a = 8'h7F; bus8.in_b = 8'h01;
    bus8.set_cc = 1'b1; bus8.out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if ({bus8.out_valid, bus8.out, bus8.cc} !== {1'b1, 8'h80, 3'b011}) begin
      errs++; $display("FAIL w8_add_of got v=%b out=%h cc=%b exp v=1 out=80 cc=011", bus8.out_valid, bus8.out, bus8.cc); end
    for (int i = 0; i < 100; i++) begin
      a = 8'($urandom); b = 8'($urandom);
      if (i % 7 == 0) b = a;
      bus8.op = 2'($urandom_range(0, 3)); bus8.in_a = a; bus8.in_b = b;
      ref8(bus8.op, a, b, r, f);
      @(posedge clk); #1;
      checks++; if ({bus8.out, bus8.cc} !== {r, f}) begin
        errs++; $display("FAIL w8_rnd[%0d] got out=%h cc=%b exp out=%h cc=%b", i, bus8.out, bus8.cc, r, f); end
    end
    bus8.in_valid = 1'b0;
  endtask

  initial begin
    checks = 0; errs = 0;
    m_valid = 1'b0; m_out = '0; m_cc = 3'b100;
    rst = 1'b1;
    drive(1'b0, 2'd0, '0, '0, 1'b0, 1'b0);
    bus8.in_valid = 1'b0; bus8.op = 2'd0; bus8.in_a = '0; bus8.in_b = '0;
    bus8.set_cc = 1'b0; bus8.out_ready = 1'b1;
    test_reset();
    test_and_xor();
    test_sub_add_of();
    test_cc_hold();
    test_backpressure();
    test_reset_mid_stall();
    test_random();
    test_width8();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, registered successor to the combinational 64-bit logic units in the Y86-64 ALU.
- Performs ADD, SUB, AND or XOR on two WIDTH-bit operands with one cycle of latency.
- Uses a valid/ready handshake on input and output, with backpressure.
- Holds the Y86 condition-code register (ZF, SF, OF) and updates it only on request.
- Sits between the decode/fetch operand latch and the execute/memory stage.

Parameters:
WIDTH, 64, operand and result width in bits; legal range is 8 or more.
CC_RESET, 3'b100, reset value of the condition codes as {ZF,SF,OF}.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
in_valid  input  1  operand transaction is offered
in_ready  output  1  block can accept a transaction this cycle
op  input  2  operation: 0=ADD, 1=SUB, 2=AND, 3=XOR
in_a  input  WIDTH  operand A (Y86 valA)
in_b  input  WIDTH  operand B (Y86 valB)
set_cc  input  1  update the condition codes with this transaction's flags
out_valid  output  1  result register holds an unconsumed result
out_ready  input  1  downstream accepts the result
out  output  WIDTH  registered result
cc  output  3  condition-code register {ZF,SF,OF}

Behaviour:
- Reset (rst=1 at a clk edge) takes priority over every other input:
  - out_valid=0, out=0, cc=CC_RESET.
  - Any held result is discarded; no handshake completes on that edge.
- in_ready is combinational: in_ready = !out_valid || out_ready.
  - Back-to-back accepts at one result per cycle are therefore allowed.
- Accept: in_valid && in_ready at a clk edge. On the next cycle:
  - out = f(op, in_a, in_b) and out_valid=1.
  - Latency is 1 cycle.
- Result definitions, all modulo 2^WIDTH:
  - ADD: out = in_b + in_a.
  - SUB: out = in_b - in_a.
  - AND: out = in_b & in_a.
  - XOR: out = in_b ^ in_a.
- Flags are computed from the result r before registering:
  - ZF = (r == 0).
  - SF = r[WIDTH-1].
  - OF for ADD = (a_s == b_s) && (r_s != a_s).
  - OF for SUB = (a_s != b_s) && (r_s != b_s).
  - OF for AND and XOR = 0.
  - a_s, b_s and r_s are the MSBs of in_a, in_b and r.
- CC update happens on the same edge as the accept, so the new cc becomes visible together with out_valid.
  - It occurs only when the transaction is accepted and set_cc=1.
  - Otherwise cc holds, including when set_cc=1 while in_ready=0 or in_valid=0.
- Output consumption: out_valid && out_ready at a clk edge.
  - If no new accept happens on that edge, out_valid falls to 0.
  - out keeps its last value; it is not cleared.
- Simultaneous consume and accept: out_valid stays 1 and out takes the new result.
- Stall: when out_valid=1 and out_ready=0, then in_ready=0, and out and out_valid hold stable until consumed.
- in_* and op are ignored while in_ready=0 or in_valid=0.
- No internal state exists beyond out, out_valid and cc.

Test Plan:
- Reset check: assert rst for 2 cycles with WIDTH=64 -> out_valid=0, out=0, cc=3'b100, in_ready=1.
- AND: op=2, in_a=64'h26, in_b=64'h31, set_cc=1, out_ready=1 -> next cycle out=64'h20, out_valid=1, cc=3'b000.
  - Then op=3 with the same operands -> out=64'h17.
- SUB zero, then ADD overflow:
  - op=1, in_a=in_b=5, set_cc=1 -> out=0, cc=3'b100.
  - Then op=0, in_a=64'h7FFF_FFFF_FFFF_FFFF, in_b=1, set_cc=1 -> out=64'h8000_0000_0000_0000, cc=3'b011.
- CC hold: op=1, in_a=3, in_b=1, set_cc=0 -> out=64'hFFFF_FFFF_FFFF_FFFE, cc unchanged from the previous value.
- Backpressure:
  - Accept ADD 2+3 with out_ready=0 for 3 cycles -> out=5 and out_valid=1 hold, in_ready=0.
  - A second offered op is not accepted until out_ready=1; with in_valid held, that edge both consumes 5 and accepts the new op.
- Reset mid-stall: with out_valid=1 and out_ready=0, pulse rst for 1 cycle -> out_valid=0, out=0, cc=3'b100 on the next edge, in_ready=1.
- Parametric run: repeat the ADD-overflow case with WIDTH=8, in_a=8'h7F, in_b=8'h01 -> out=8'h80, cc=3'b011.
